// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: NOP encoding, jump opcodes,
// the fetch FSM state type and a word-alignment helper.
package mips_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [5:0]  OP_J      = 6'h02;
  localparam logic [5:0]  OP_JAL    = 6'h03;

  typedef enum logic {
    RUN   = 1'b0,
    REDIR = 1'b1
  } fetch_state_t;

  // Force an address onto a word boundary
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_npc_sel.sv
// Redirect target selection for the fetch stage.
// JR has priority over JUMP, which has priority over the branch adder target.
// The result is always word aligned.
module fetch_npc_sel
  import mips_pkg::*;
(
  input  logic        i_jr,
  input  logic        i_jump,
  input  logic [31:0] i_btgt,
  input  logic [31:0] i_jrtgt,
  input  logic [3:0]  i_idpc4_hi,
  input  logic [25:0] i_instr_index,
  output logic [31:0] o_target
);

  logic [31:0] w_raw;

  // Pick the raw target by priority, then drop the byte-offset bits
  always_comb begin
    w_raw = i_btgt;
    if (i_jr) begin
      w_raw = i_jrtgt;
    end else if (i_jump) begin
      w_raw = {i_idpc4_hi, i_instr_index, 2'b00};
    end
    o_target = align_word(w_raw);
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage plus IF/ID pipeline register.
// Drives a variable-latency instruction memory handshake, holds one word in a
// skid buffer when ID stalls, and parks in REDIR while a redirect waits for
// the outstanding fetch to complete.
// Optional build macro FETCH_PERF_EN adds stall/redirect performance counters.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef FETCH_PERF_EN
  ,
  parameter int PERF_W = 32
`endif
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        WPCIR,
  input  logic        BRANCH,
  input  logic        JUMP,
  input  logic        JR,
  input  logic [31:0] BTGT,
  input  logic [31:0] JRTGT,
  output logic [31:0] IMEM_ADDR,
  output logic        IMEM_REQ,
  input  logic [31:0] IMEM_RDATA,
  input  logic        IMEM_RDY,
  output logic [31:0] IDIR,
  output logic [31:0] IDPC4,
  output logic        IDVALID
`ifdef FETCH_PERF_EN
  ,
  output logic [PERF_W-1:0] PERF_STALL,
  output logic [PERF_W-1:0] PERF_REDIR
`endif
);

  fetch_state_t r_state, w_state_nxt;
  logic [31:0]  r_pc, w_pc_nxt;
  logic [31:0]  r_idir, w_idir_nxt;
  logic [31:0]  r_idpc4, w_idpc4_nxt;
  logic         r_idvalid, w_idvalid_nxt;
  logic         r_skid_v, w_skid_v_nxt;
  logic [31:0]  r_skid, w_skid_nxt;
  logic [31:0]  r_skid_pc4, w_skid_pc4_nxt;
  logic [31:0]  r_rtgt, w_rtgt_nxt;

  logic         w_req;
  logic         w_ack;
  logic         w_redirect;
  logic         w_stall_evt;
  logic         w_redir_evt;
  logic [31:0]  w_pc4;
  logic [31:0]  w_target;

  assign w_req      = (r_state == REDIR) | ((r_state == RUN) & ~r_skid_v);
  assign w_ack      = IMEM_RDY & w_req;
  assign w_redirect = BRANCH & ~WPCIR;
  assign w_pc4      = r_pc + 32'd4;

  assign IMEM_REQ   = w_req;
  assign IMEM_ADDR  = r_pc;
  assign IDIR       = r_idir;
  assign IDPC4      = r_idpc4;
  assign IDVALID    = r_idvalid;

  fetch_npc_sel u_npc_sel (
    .i_jr          (JR),
    .i_jump        (JUMP),
    .i_btgt        (BTGT),
    .i_jrtgt       (JRTGT),
    .i_idpc4_hi    (r_idpc4[31:28]),
    .i_instr_index (r_idir[25:0]),
    .o_target      (w_target)
  );

  // Next-state logic: redirect beats stall, a held skid word beats a fresh fetch
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_idir_nxt     = r_idir;
    w_idpc4_nxt    = r_idpc4;
    w_idvalid_nxt  = r_idvalid;
    w_skid_v_nxt   = r_skid_v;
    w_skid_nxt     = r_skid;
    w_skid_pc4_nxt = r_skid_pc4;
    w_rtgt_nxt     = r_rtgt;
    w_stall_evt    = 1'b0;
    w_redir_evt    = 1'b0;
    case (r_state)
      REDIR: begin
        w_idir_nxt    = NOP_INSTR;
        w_idvalid_nxt = 1'b0;
        if (w_ack) begin
          w_pc_nxt    = r_rtgt;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (w_redirect) begin
          w_redir_evt   = 1'b1;
          w_idir_nxt    = NOP_INSTR;
          w_idvalid_nxt = 1'b0;
          w_skid_v_nxt  = 1'b0;
          if (w_ack || !w_req) begin
            w_pc_nxt = w_target;
          end else begin
            w_rtgt_nxt  = w_target;
            w_state_nxt = REDIR;
          end
        end else if (WPCIR) begin
          w_stall_evt = 1'b1;
          if (w_ack) begin
            w_skid_v_nxt   = 1'b1;
            w_skid_nxt     = IMEM_RDATA;
            w_skid_pc4_nxt = w_pc4;
            w_pc_nxt       = w_pc4;
          end
        end else if (r_skid_v) begin
          w_idir_nxt    = r_skid;
          w_idpc4_nxt   = r_skid_pc4;
          w_idvalid_nxt = 1'b1;
          w_skid_v_nxt  = 1'b0;
        end else if (w_ack) begin
          w_idir_nxt    = IMEM_RDATA;
          w_idpc4_nxt   = w_pc4;
          w_idvalid_nxt = 1'b1;
          w_pc_nxt      = w_pc4;
        end else begin
          w_idir_nxt    = NOP_INSTR;
          w_idvalid_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  // State register for the FSM, PC, IF/ID and skid buffer
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= RUN;
      r_pc       <= RESET_PC;
      r_idir     <= NOP_INSTR;
      r_idpc4    <= 32'h0;
      r_idvalid  <= 1'b0;
      r_skid_v   <= 1'b0;
      r_skid     <= 32'h0;
      r_skid_pc4 <= 32'h0;
      r_rtgt     <= 32'h0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_idir     <= w_idir_nxt;
      r_idpc4    <= w_idpc4_nxt;
      r_idvalid  <= w_idvalid_nxt;
      r_skid_v   <= w_skid_v_nxt;
      r_skid     <= w_skid_nxt;
      r_skid_pc4 <= w_skid_pc4_nxt;
      r_rtgt     <= w_rtgt_nxt;
    end
  end

`ifdef FETCH_PERF_EN
  logic [PERF_W-1:0] r_perf_stall;
  logic [PERF_W-1:0] r_perf_redir;

  // Free-running wrap-around counters of RUN stall cycles and taken redirects
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_perf_stall <= '0;
      r_perf_redir <= '0;
    end else begin
      if (w_stall_evt) r_perf_stall <= r_perf_stall + 1'b1;
      if (w_redir_evt) r_perf_redir <= r_perf_redir + 1'b1;
    end
  end

  assign PERF_STALL = r_perf_stall;
  assign PERF_REDIR = r_perf_redir;
`else
  logic w_perf_unused;
  assign w_perf_unused = w_stall_evt ^ w_redir_evt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random
// traffic, all compared against a transaction-level reference model.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        WPCIR = 1'b0;
  logic        BRANCH = 1'b0;
  logic        JUMP = 1'b0;
  logic        JR = 1'b0;
  logic [31:0] BTGT = 32'h0;
  logic [31:0] JRTGT = 32'h0;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_REQ;
  logic [31:0] IMEM_RDATA = 32'h0;
  logic        IMEM_RDY = 1'b0;
  logic [31:0] IDIR;
  logic [31:0] IDPC4;
  logic        IDVALID;
`ifdef FETCH_PERF_EN
  logic [31:0] PERF_STALL;
  logic [31:0] PERF_REDIR;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model: architectural view of the fetch stage
  logic [31:0] mPc;
  logic [31:0] mIdir;
  logic [31:0] mIdpc4;
  logic        mIdvalid;
  logic        mPending;
  logic [31:0] mRtgt;
  logic [31:0] skidData[$];
  logic [31:0] skidPc4[$];
  int          mStalls;
  int          mRedirs;

  fetch_stage dut (
    .CLK        (CLK),
    .RST        (RST),
    .WPCIR      (WPCIR),
    .BRANCH     (BRANCH),
    .JUMP       (JUMP),
    .JR         (JR),
    .BTGT       (BTGT),
    .JRTGT      (JRTGT),
    .IMEM_ADDR  (IMEM_ADDR),
    .IMEM_REQ   (IMEM_REQ),
    .IMEM_RDATA (IMEM_RDATA),
    .IMEM_RDY   (IMEM_RDY),
    .IDIR       (IDIR),
    .IDPC4      (IDPC4),
    .IDVALID    (IDVALID)
`ifdef FETCH_PERF_EN
    ,
    .PERF_STALL (PERF_STALL),
    .PERF_REDIR (PERF_REDIR)
`endif
  );

  // Free-running clock
  always #5 CLK = ~CLK;

  function automatic logic mReq();
    return mPending || (skidData.size() == 0);
  endfunction

  task automatic modelReset();
    mPc = 32'h0;
    mIdir = 32'h0;
    mIdpc4 = 32'h0;
    mIdvalid = 1'b0;
    mPending = 1'b0;
    mRtgt = 32'h0;
    skidData.delete();
    skidPc4.delete();
    mStalls = 0;
    mRedirs = 0;
  endtask

  task automatic modelStep(input logic wpcir, input logic branch, input logic jump,
                           input logic jr, input logic [31:0] btgt, input logic [31:0] jrtgt,
                           input logic rdy, input logic [31:0] rdata);
    logic ack;
    logic [31:0] tgt;
    ack = rdy && mReq();
    if (mPending) begin
      mIdir = 32'h0;
      mIdvalid = 1'b0;
      if (ack) begin
        mPc = mRtgt;
        mPending = 1'b0;
      end
    end else if (branch && !wpcir) begin
      if (jr) tgt = jrtgt;
      else if (jump) tgt = {mIdpc4[31:28], mIdir[25:0], 2'b00};
      else tgt = btgt;
      tgt = tgt & 32'hFFFF_FFFC;
      mRedirs++;
      mIdir = 32'h0;
      mIdvalid = 1'b0;
      if (ack || !mReq()) mPc = tgt;
      else begin
        mPending = 1'b1;
        mRtgt = tgt;
      end
      skidData.delete();
      skidPc4.delete();
    end else if (wpcir) begin
      mStalls++;
      if (ack) begin
        skidData.push_back(rdata);
        skidPc4.push_back(mPc + 32'd4);
        mPc = mPc + 32'd4;
      end
    end else if (skidData.size() != 0) begin
      mIdir = skidData.pop_front();
      mIdpc4 = skidPc4.pop_front();
      mIdvalid = 1'b1;
    end else if (ack) begin
      mIdir = rdata;
      mIdpc4 = mPc + 32'd4;
      mIdvalid = 1'b1;
      mPc = mPc + 32'd4;
    end else begin
      mIdir = 32'h0;
      mIdvalid = 1'b0;
    end
  endtask

  task automatic checkOutput(input string tag);
    checks++;
    assert (IDIR === mIdir) else begin
      failures++;
      $error("[TB] FAIL %s IDIR observed=%h expected=%h", tag, IDIR, mIdir);
    end
    checks++;
    assert (IDPC4 === mIdpc4) else begin
      failures++;
      $error("[TB] FAIL %s IDPC4 observed=%h expected=%h", tag, IDPC4, mIdpc4);
    end
    checks++;
    assert (IDVALID === mIdvalid) else begin
      failures++;
      $error("[TB] FAIL %s IDVALID observed=%b expected=%b", tag, IDVALID, mIdvalid);
    end
    checks++;
    assert (IMEM_REQ === mReq()) else begin
      failures++;
      $error("[TB] FAIL %s IMEM_REQ observed=%b expected=%b", tag, IMEM_REQ, mReq());
    end
    checks++;
    assert (IMEM_ADDR === mPc) else begin
      failures++;
      $error("[TB] FAIL %s IMEM_ADDR observed=%h expected=%h", tag, IMEM_ADDR, mPc);
    end
`ifdef FETCH_PERF_EN
    checks++;
    assert (PERF_STALL === 32'(mStalls)) else begin
      failures++;
      $error("[TB] FAIL %s PERF_STALL observed=%0d expected=%0d", tag, PERF_STALL, mStalls);
    end
    checks++;
    assert (PERF_REDIR === 32'(mRedirs)) else begin
      failures++;
      $error("[TB] FAIL %s PERF_REDIR observed=%0d expected=%0d", tag, PERF_REDIR, mRedirs);
    end
`endif
  endtask

  // Drive one cycle of inputs; memory answers only when a request is expected
  task automatic applyStimulus(input string tag, input logic wpcir, input logic branch,
                               input logic jump, input logic jr, input logic [31:0] btgt,
                               input logic [31:0] jrtgt, input logic rdy);
    logic rdyEff;
    logic [31:0] rdata;
    rdyEff = rdy && mReq();
    rdata = mPc ^ 32'hA5A5_0000;
    WPCIR = wpcir;
    BRANCH = branch;
    JUMP = jump;
    JR = jr;
    BTGT = btgt;
    JRTGT = jrtgt;
    IMEM_RDY = rdyEff;
    IMEM_RDATA = rdyEff ? rdata : 32'hDEAD_BEEF;
    modelStep(wpcir, branch, jump, jr, btgt, jrtgt, rdyEff, rdata);
    @(posedge CLK);
    #1;
    checkOutput(tag);
  endtask

  task automatic doReset(input int cycles);
    RST = 1'b1;
    WPCIR = 1'b0;
    BRANCH = 1'b0;
    JUMP = 1'b0;
    JR = 1'b0;
    IMEM_RDY = 1'b0;
    repeat (cycles) @(posedge CLK);
    #1;
    RST = 1'b0;
    modelReset();
    checkOutput("reset");
  endtask

  initial begin
    modelReset();
    $display("[TB] start");

    doReset(2);

    for (int i = 0; i < 2; i++) applyStimulus("seq0wait", 0, 0, 0, 0, 32'h0, 32'h0, 1);

    for (int i = 0; i < 3; i++) applyStimulus("waitbubble", 0, 0, 0, 0, 32'h0, 32'h0, 0);
    applyStimulus("waitdone", 0, 0, 0, 0, 32'h0, 32'h0, 1);
    applyStimulus("seq", 0, 0, 0, 0, 32'h0, 32'h0, 1);

    for (int i = 0; i < 3; i++) applyStimulus("stallskid", 1, 0, 0, 0, 32'h0, 32'h0, 1);
    applyStimulus("skidrelease", 0, 0, 0, 0, 32'h0, 32'h0, 1);
    applyStimulus("after_skid", 0, 0, 0, 0, 32'h0, 32'h0, 1);

    applyStimulus("branch40", 0, 1, 0, 0, 32'h40, 32'h0, 1);
    applyStimulus("at40", 0, 0, 0, 0, 32'h0, 32'h0, 1);

    applyStimulus("branch20", 0, 1, 0, 0, 32'h20, 32'h0, 1);
    applyStimulus("jr_wait", 0, 1, 0, 1, 32'h0, 32'h103, 0);
    applyStimulus("redir_hold", 1, 1, 0, 0, 32'h0, 32'h0, 0);
    applyStimulus("redir_done", 0, 0, 0, 0, 32'h0, 32'h0, 1);
    for (int i = 0; i < 2; i++) applyStimulus("at100", 0, 0, 0, 0, 32'h0, 32'h0, 1);

    applyStimulus("jump", 0, 1, 1, 0, 32'h40, 32'h0, 1);
    applyStimulus("after_jump", 0, 0, 0, 0, 32'h0, 32'h0, 1);

    applyStimulus("branch_stalled", 1, 1, 0, 0, 32'h80, 32'h0, 1);
    applyStimulus("stall_release", 0, 0, 0, 0, 32'h0, 32'h0, 1);

    applyStimulus("wrap_branch", 0, 1, 0, 0, 32'hFFFF_FFFC, 32'h0, 1);
    applyStimulus("wrap", 0, 0, 0, 0, 32'h0, 32'h0, 1);
    applyStimulus("wrapped", 0, 0, 0, 0, 32'h0, 32'h0, 1);

    applyStimulus("enter_redir", 0, 1, 0, 0, 32'h200, 32'h0, 0);
    doReset(1);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        doReset(1);
      end else begin
        applyStimulus("random",
                      ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 5) == 0),
                      1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) == 0),
                      $urandom(), $urandom(),
                      ($urandom_range(0, 3) != 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
